// File: rtl/riscv_exec_ctrl_pkg.sv
// Shared constants for the RV32I execute controller: ALU control codes,
// opcode/funct3 values, FSM state encoding and the accept-time decoder.
// Optional feature macro: RISCV_ITER_SHIFT_EN (selects the iterative SRA).
package riscv_exec_ctrl_pkg;

    localparam logic [3:0] aluop_nop = 4'd0;
    localparam logic [3:0] aluop_add = 4'd1;
    localparam logic [3:0] aluop_or  = 4'd2;
    localparam logic [3:0] aluop_sra = 4'd3;

    localparam logic [6:0] opc_op     = 7'b0110011;
    localparam logic [6:0] opc_op_imm = 7'b0010011;
    localparam logic [6:0] opc_load   = 7'b0000011;
    localparam logic [6:0] opc_store  = 7'b0100011;
    localparam logic [6:0] opc_jal    = 7'b1101111;

    localparam logic [2:0] f3_add = 3'b000;
    localparam logic [2:0] f3_mem = 3'b010;
    localparam logic [2:0] f3_or  = 3'b110;
    localparam logic [2:0] f3_sra = 3'b101;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_shift = 2'd1;
    localparam logic [1:0] st_done  = 2'd2;

    // funct7 deliberately plays no part: SUB/SRL share codes with ADD/SRA here.
    function automatic logic [3:0] decode_aluop(input logic [6:0] opcode,
                                                input logic [2:0] funct3);
        logic [3:0] op;
        op = aluop_nop;
        if (opcode == opc_jal)
            op = aluop_add;
        else if (opcode == opc_op && funct3 == f3_add)
            op = aluop_add;
        else if (opcode == opc_load && funct3 == f3_mem)
            op = aluop_add;
        else if (opcode == opc_store && funct3 == f3_mem)
            op = aluop_add;
        else if (opcode == opc_op_imm && funct3 == f3_or)
            op = aluop_or;
        else if (opcode == opc_op && funct3 == f3_sra)
            op = aluop_sra;
        return op;
    endfunction

endpackage

// File: rtl/riscv_exec_ctrl_alu_core.sv
// Single-cycle combinational ALU used for every operation that completes
// in one cycle (and for SRA when the iterative shifter is not built).
module riscv_alu_core
    import riscv_exec_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      aluctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    // Select the operation; unknown codes produce zero.
    always_comb begin
        result = '0;
        case (aluctl)
            aluop_add: result = op_a + op_b;
            aluop_or:  result = op_a | op_b;
            aluop_sra: result = $signed(op_a) >>> op_b[4:0];
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_exec_ctrl.sv
// Execute-stage controller: accepts one decoded request at a time, produces
// a registered result and holds it under valid/ready backpressure.
// RISCV_ITER_SHIFT_EN defined: SRA shifts one bit per cycle in SHIFT state.
// RISCV_ITER_SHIFT_EN undefined: SRA is single-cycle through the ALU core.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | iterative arithmetic right shift in progress
// DONE  | result valid, waiting for consumer
module riscv_exec_ctrl
    import riscv_exec_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      aluctl_o,
    output logic            busy_o
);

    logic [1:0]      state;
    logic [XLEN-1:0] result_q;
    logic [3:0]      aluctl_q;
    logic [6:0]      funct7_q;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] alu_result;
    logic            accept;

`ifdef RISCV_ITER_SHIFT_EN
    logic [4:0]      cnt_q;
`endif

    // funct7 is kept for observability only; it never steers decode.
    logic funct7_unused;
    assign funct7_unused = ^funct7_q;

    assign dec_op  = decode_aluop(opcode_i, funct3_i);
    assign accept  = valid_i && (state == st_idle);

    assign ready_o  = (state == st_idle);
    assign valid_o  = (state == st_done);
    assign busy_o   = (state != st_idle);
    assign result_o = result_q;
    assign aluctl_o = aluctl_q;

    riscv_alu_core #(.XLEN(XLEN)) u_alu (
        .aluctl (dec_op),
        .op_a   (op_a_i),
        .op_b   (op_b_i),
        .result (alu_result)
    );

    // Sequence each request: capture on accept, optionally shift, hold until handshake.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= st_idle;
            result_q <= '0;
            aluctl_q <= aluop_nop;
            funct7_q <= '0;
`ifdef RISCV_ITER_SHIFT_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state)
                st_idle: begin
                    if (accept) begin
                        aluctl_q <= dec_op;
                        funct7_q <= funct7_i;
`ifdef RISCV_ITER_SHIFT_EN
                        if (dec_op == aluop_sra && op_b_i[4:0] != 5'd0) begin
                            result_q <= op_a_i;
                            cnt_q    <= op_b_i[4:0];
                            state    <= st_shift;
                        end else begin
                            result_q <= alu_result;
                            state    <= st_done;
                        end
`else
                        result_q <= alu_result;
                        state    <= st_done;
`endif
                    end
                end
`ifdef RISCV_ITER_SHIFT_EN
                st_shift: begin
                    result_q <= {result_q[XLEN-1], result_q[XLEN-1:1]};
                    cnt_q    <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1)
                        state <= st_done;
                end
`endif
                st_done: begin
                    if (ready_i)
                        state <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_exec_ctrl.sv
// Scoreboard bench for riscv_exec_ctrl: directed corner cases plus random
// requests, checked against an arithmetic reference model.
module tb_riscv_exec_ctrl;
    import riscv_exec_ctrl_pkg::aluop_nop;
    import riscv_exec_ctrl_pkg::aluop_add;
    import riscv_exec_ctrl_pkg::aluop_or;
    import riscv_exec_ctrl_pkg::aluop_sra;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [3:0]  aluctl_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    riscv_exec_ctrl #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .aluctl_o (aluctl_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the decode table and arithmetic rules.
    function automatic void model(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] op,
                                  output int lat);
        logic signed [31:0] sa;
        sa  = a;
        lat = 1;
        if (opc == 7'h6F || (opc == 7'h33 && f3 == 3'd0) ||
            (opc == 7'h03 && f3 == 3'd2) || (opc == 7'h23 && f3 == 3'd2)) begin
            op = aluop_add;
            r  = a + b;
        end else if (opc == 7'h13 && f3 == 3'd6) begin
            op = aluop_or;
            r  = a | b;
        end else if (opc == 7'h33 && f3 == 3'd5) begin
            op = aluop_sra;
            r  = sa >>> b[4:0];
`ifdef RISCV_ITER_SHIFT_EN
            if (b[4:0] != 5'd0)
                lat = int'(b[4:0]) + 1;
`endif
        end else begin
            op = aluop_nop;
            r  = 32'd0;
        end
    endfunction

    // Monitor: every cycle a result is presented it must match the queue head
    // (also proving it stays stable under backpressure); pop on handshake.
    always @(negedge clk_i) begin
        if (rstn_i && valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got result 0x%08h with nothing outstanding", result_o);
            end else begin
                chk("result", result_o, exp_q[0].res);
                chk("aluctl", 32'(aluctl_o), 32'(exp_q[0].op));
                if (ready_i)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input int bp);
        exp_t e;
        int   exp_lat;
        int   lat;
        model(opc, f3, a, b, e.res, e.op, exp_lat);
        @(posedge clk_i);
        #2;
        valid_i  = 1'b1;
        opcode_i = opc;
        funct3_i = f3;
        funct7_i = f7;
        op_a_i   = a;
        op_b_i   = b;
        ready_i  = (bp == 0);
        chk("ready_idle", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        exp_q.push_back(e);
        #2;
        // valid_i stays high with junk fields while busy: must be ignored
        opcode_i = 7'($urandom);
        funct3_i = 3'($urandom);
        funct7_i = 7'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
            if (!valid_o)
                chk("busy_shift", 32'(busy_o), 32'd1);
        end while (!valid_o && lat < 80);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ready_busy", 32'(ready_o), 32'd0);
        if (bp > 0) begin
            repeat (bp) @(posedge clk_i);
            #2 ready_i = 1'b1;
        end
        @(posedge clk_i);
        #2;
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk("post_valid", 32'(valid_o), 32'd0);
        chk("post_ready", 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        rstn_i   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        opcode_i = '0;
        funct3_i = '0;
        funct7_i = '0;
        op_a_i   = '0;
        op_b_i   = '0;
        repeat (3) @(posedge clk_i);
        #2 rstn_i = 1'b1;
        #1;
        chk("rst_valid",  32'(valid_o),  32'd0);
        chk("rst_ready",  32'(ready_o),  32'd1);
        chk("rst_busy",   32'(busy_o),   32'd0);
        chk("rst_result", result_o,      32'd0);
        chk("rst_aluctl", 32'(aluctl_o), 32'(aluop_nop));

        run_op(7'h33, 3'd0, 7'h00, 32'h0000_0005, 32'h0000_0003, 0);
        run_op(7'h33, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0004, 0);
        run_op(7'h33, 3'd5, 7'h20, 32'h8000_1234, 32'h0000_0000, 1);
        run_op(7'h33, 3'd5, 7'h20, 32'hC000_0001, 32'h0000_001F, 0);
        run_op(7'h13, 3'd6, 7'h00, 32'h0F0F_0000, 32'h0000_00FF, 3);
        run_op(7'h37, 3'd0, 7'h00, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(7'h6F, 3'd7, 7'h00, 32'h0000_1000, 32'h0000_0FFC, 2);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: begin opc = 7'h33; f3 = 3'd0; end
                1: begin opc = 7'h03; f3 = 3'd2; end
                2: begin opc = 7'h23; f3 = 3'd2; end
                3: begin opc = 7'h6F; f3 = 3'($urandom); end
                4: begin opc = 7'h13; f3 = 3'd6; end
                5: begin opc = 7'h33; f3 = 3'd5; end
                6: begin opc = 7'($urandom); f3 = 3'($urandom); end
                default: begin opc = 7'h13; f3 = 3'($urandom); end
            endcase
            run_op(opc, f3, 7'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a long SRA abandons it.
        @(posedge clk_i);
        #2;
        valid_i  = 1'b1;
        opcode_i = 7'h33;
        funct3_i = 3'd5;
        op_a_i   = 32'h8765_4321;
        op_b_i   = 32'd20;
        ready_i  = 1'b0;
        @(posedge clk_i);
        exp_q.push_back('{res: 32'hFFFF_F876, op: aluop_sra});
        #2 valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        chk("midrst_valid",  32'(valid_o),  32'd0);
        chk("midrst_busy",   32'(busy_o),   32'd0);
        chk("midrst_result", result_o,      32'd0);
        chk("midrst_aluctl", 32'(aluctl_o), 32'(aluop_nop));
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2 rstn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("postrst_valid", 32'(valid_o), 32'd0);
        run_op(7'h03, 3'd2, 7'h00, 32'h0000_0100, 32'h0000_0020, 1);
        run_op(7'h33, 3'd5, 7'h20, 32'hF000_0000, 32'h0000_0008, 0);

        repeat (3) @(posedge clk_i);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
